// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: direct-mapped instruction cache with single-line refill sequencer.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   fetch_req/fetch_pc  fetch lookup request and byte address (bits [1:0] ignored)
//   inst_out/inst_hit   combinational lookup result, valid only while IDLE
//   fetch_stall         fetch_req without a hit; pipeline holds
//   flush               invalidate all lines (deferred to FILL while a refill is active)
//   mem_req_*           line refill request channel (valid/ready, line-aligned address)
//   mem_rvalid/rdata    refill beat return channel, LINE_WORDS beats per line
//   busy                refill sequencer not IDLE
// Optional macro ICACHE_PERF_EN adds saturating perf_hit_cnt / perf_miss_cnt outputs.
module icache_fetch_ctrl #(
   parameter int LINE_WORDS = 4,
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [31:0] fetch_pc,
   output logic [31:0] inst_out,
   output logic        inst_hit,
   output logic        fetch_stall,
   input  logic        flush,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        busy
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] perf_hit_cnt,
   output logic [31:0] perf_miss_cnt
`endif
);
   localparam int W     = $clog2(LINE_WORDS);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TW    = 30 - W - INDEX_BITS;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_FILL} state_t;

   state_t                  r_state, w_next;
   logic [LINES-1:0]        r_valid;
   logic [TW-1:0]           r_tag  [LINES];
   logic [31:0]             r_data [LINES*LINE_WORDS];
   logic [29-W:0]           r_line;
   logic [W-1:0]            r_cnt;
   logic                    r_flush_pend;

   logic [W-1:0]            w_word;
   logic [INDEX_BITS-1:0]   w_idx, w_fidx;
   logic [TW-1:0]           w_tag, w_ftag;
   logic                    w_line_hit, w_miss_start, w_last_beat, w_beat, w_fill_flush;
   logic                    w_unused_pc;

   assign w_word       = fetch_pc[W+1:2];
   assign w_idx        = fetch_pc[W+1+INDEX_BITS:W+2];
   assign w_tag        = fetch_pc[31:W+2+INDEX_BITS];
   assign w_unused_pc  = ^fetch_pc[1:0];
   assign w_fidx       = r_line[INDEX_BITS-1:0];
   assign w_ftag       = r_line[29-W:INDEX_BITS];

   assign w_line_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign inst_hit     = fetch_req && w_line_hit && (r_state == S_IDLE);
   assign inst_out     = r_data[{w_idx, w_word}];
   assign fetch_stall  = fetch_req && !inst_hit;
   assign mem_req_addr = {r_line, {(W+2){1'b0}}};

   assign w_miss_start = (r_state == S_IDLE) && fetch_req && !w_line_hit && !flush;
   assign w_beat       = (r_state == S_RECV) && mem_rvalid;
   assign w_last_beat  = r_cnt == W'(LINE_WORDS - 1);
   // A flush arriving in the FILL cycle itself still suppresses the new line.
   assign w_fill_flush = r_flush_pend || flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      mem_req_valid = 1'b0;
      busy          = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_miss_start) w_next = S_REQ;
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) w_next = S_RECV;
         end
         S_RECV:  if (w_beat && w_last_beat) w_next = S_FILL;
         S_FILL:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid      <= '0;
         r_line       <= '0;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         // The victim line is invalidated up front so a half-refilled line never hits.
         if (w_miss_start) begin
            r_line         <= fetch_pc[31:W+2];
            r_valid[w_idx] <= 1'b0;
         end
         if (r_state == S_IDLE && flush) r_valid <= '0;
         if (r_state != S_IDLE && flush) r_flush_pend <= 1'b1;
         if (w_beat) r_cnt <= r_cnt + 1'b1;
         if (r_state == S_FILL) begin
            r_flush_pend <= 1'b0;
            if (w_fill_flush) r_valid <= '0;
            else              r_valid[w_fidx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_beat) r_data[{w_fidx, r_cnt}] <= mem_rdata;
      if (r_state == S_FILL) r_tag[w_fidx] <= w_ftag;
   end

`ifdef ICACHE_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_hit_cnt  <= '0;
         perf_miss_cnt <= '0;
      end else begin
         if (inst_hit && perf_hit_cnt != '1) perf_hit_cnt <= perf_hit_cnt + 32'd1;
         if (w_miss_start && perf_miss_cnt != '1) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// tb_icache_fetch_ctrl: directed scoreboard bench for icache_fetch_ctrl (default parameters).
module tb_icache_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst, fetch_req, flush, mem_req_ready, mem_rvalid;
   logic [31:0] fetch_pc, mem_rdata;
   logic [31:0] inst_out, mem_req_addr;
   logic        inst_hit, fetch_stall, mem_req_valid, busy;
   int          total = 0;
   int          bad = 0;
   logic [31:0] hit_q[$];
   logic [31:0] req_q[$];

   icache_fetch_ctrl dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .inst_out(inst_out), .inst_hit(inst_hit), .fetch_stall(fetch_stall), .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_miss(input logic [31:0] pc, input logic [3:0][31:0] d, input int bp, input int fl);
      fetch_req = 1'b1; fetch_pc = pc; flush = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0;
      req_q.push_back({pc[31:4], 4'h0});
      @(negedge clk);
      check("miss_stall", fetch_stall, 1);
      check("miss_busy", busy, 0);
      check("miss_noreq", mem_req_valid, 0);
      tick();
      for (int i = 0; i < bp; i++) begin
         mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
         @(negedge clk);
         check("bp_valid", mem_req_valid, 1);
         check("bp_addr", mem_req_addr, {pc[31:4], 4'h0});
         tick();
      end
      mem_rvalid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      check("req_valid", mem_req_valid, 1);
      check("req_busy", busy, 1);
      tick();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1'b1; mem_rdata = d[i]; flush = (i == fl);
         @(negedge clk);
         check("recv_stall", fetch_stall, 1);
         check("recv_noreq", mem_req_valid, 0);
         tick();
      end
      mem_rvalid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("fill_busy", busy, 1);
      check("fill_stall", fetch_stall, 1);
      tick();
   endtask

   task automatic expect_hit(input logic [31:0] pc, input logic [31:0] exp);
      fetch_req = 1'b1; fetch_pc = pc; flush = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0;
      hit_q.push_back(exp);
      @(negedge clk);
      check("hit_stall", fetch_stall, 0);
      check("hit_busy", busy, 0);
      check("hit_noreq", mem_req_valid, 0);
      tick();
   endtask

   initial begin
      rst = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h8000_0000; flush = 1'b0;
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               if (inst_hit) begin
                  if (hit_q.size() == 0) begin
                     total++; bad++;
                     $display("FAIL unexpected_hit: got hit at pc %h want none", fetch_pc);
                  end else check("hit_data", inst_out, hit_q.pop_front());
               end
               if (mem_req_valid && mem_req_ready) begin
                  if (req_q.size() == 0) begin
                     total++; bad++;
                     $display("FAIL unexpected_req: got addr %h want none", mem_req_addr);
                  end else check("req_addr", mem_req_addr, req_q.pop_front());
               end
            end
         end
      join_none
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_req", mem_req_valid, 0);
      check("rst_addr", mem_req_addr, 0);
      check("rst_hit", inst_hit, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      // cold miss, hit in the first IDLE cycle, then same-line hits
      do_miss(32'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, 0, -1);
      expect_hit(32'h8000_0000, 32'h11);
      expect_hit(32'h8000_000C, 32'h44);
      expect_hit(32'h8000_0004, 32'h22);
      // conflict miss on index 0
      do_miss(32'h8000_0400, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, -1);
      expect_hit(32'h8000_0400, 32'hA0);
      expect_hit(32'h8000_0408, 32'hA2);
      do_miss(32'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, 0, -1);
      expect_hit(32'h8000_0008, 32'h33);
      // backpressure with stray beats that must be ignored
      do_miss(32'h8000_0400, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 5, -1);
      expect_hit(32'h8000_0404, 32'hA1);
      do_miss(32'h8000_0000, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, -1);
      expect_hit(32'h8000_000C, 32'hC3);
      // flush on the second beat of a refill
      do_miss(32'h8000_0020, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 0, 1);
      fetch_req = 1'b0;
      @(negedge clk);
      check("flush_busy", busy, 0);
      tick();
      do_miss(32'h8000_0020, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 0, -1);
      expect_hit(32'h8000_0028, 32'hB2);
      do_miss(32'h8000_0000, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, -1);
      expect_hit(32'h8000_0004, 32'hC1);
      // flush in IDLE on a missing pc starts no refill
      fetch_req = 1'b1; fetch_pc = 32'h8000_0030; flush = 1'b1;
      @(negedge clk);
      check("iflush_stall", fetch_stall, 1);
      tick();
      flush = 1'b0; fetch_req = 1'b0;
      @(negedge clk);
      check("iflush_busy", busy, 0);
      check("iflush_noreq", mem_req_valid, 0);
      tick();
      do_miss(32'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, 0, -1);
      expect_hit(32'h8000_0000, 32'h11);
      // reset while a request is pending
      fetch_req = 1'b1; fetch_pc = 32'h8000_0050;
      tick();
      @(negedge clk);
      check("req_pend", mem_req_valid, 1);
      tick();
      rst = 1'b0;
      #1;
      check("arst_req_valid", mem_req_valid, 0);
      check("arst_req_busy", busy, 0);
      tick();
      rst = 1'b1;
      // reset after two beats of a refill
      fetch_pc = 32'h8000_0000;
      req_q.push_back(32'h8000_0000);
      tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_rvalid = 1'b1; mem_rdata = 32'hE0 + i;
         tick();
      end
      rst = 1'b0;
      #1;
      check("arst_recv_valid", mem_req_valid, 0);
      check("arst_recv_busy", busy, 0);
      tick();
      rst = 1'b1; fetch_req = 1'b0; mem_rdata = 32'hBAD0_0BAD;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      tick();
      mem_rvalid = 1'b0;
      do_miss(32'h8000_0000, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0, -1);
      expect_hit(32'h8000_0000, 32'hD0);
      fetch_req = 1'b0;
      tick();
      check("hit_q_empty", hit_q.size(), 0);
      check("req_q_empty", req_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/icache_fetch_ctrl.md
Name: icache_fetch_ctrl

Overview:
Fetch-side cache controller between the PC predictor's fetch PC and the external instruction memory port. Holds a small direct-mapped instruction line store and answers same-cycle hit lookups. On a miss it stalls fetch and sequences a line refill over a valid/ready memory request channel plus a beat-return channel. It also services whole-cache invalidate (fence.i style flush).

Parameters:
LINE_WORDS, 4, 32-bit words per line; power of two, 2..16.
INDEX_BITS, 6, line index width; the store holds 2**INDEX_BITS lines.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst==0 resets)
fetch_req  in  1  fetch_pc valid this cycle
fetch_pc  in  32  fetch address from predictor; bits [1:0] ignored
inst_out  out  32  instruction word at fetch_pc; meaningful only when inst_hit=1
inst_hit  out  1  fetch_req and line valid and tag match, state IDLE
fetch_stall  out  1  fetch_req and not inst_hit; pipeline must hold PC and stages
flush  in  1  invalidate all lines
mem_req_valid  out  1  line request pending
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  line-aligned byte address
mem_rvalid  in  1  return beat valid
mem_rdata  in  32  return beat data
busy  out  1  state not IDLE

Behaviour:
- Address split, with W = log2(LINE_WORDS): word = pc[W+1:2], index = pc[W+1+INDEX_BITS:W+2], tag = pc[31:W+2+INDEX_BITS].
- Storage: per-line valid flop, tag register, LINE_WORDS data words. Lookup is combinational. inst_hit, inst_out and fetch_stall are combinational from fetch_pc and the stored state.
- Reset, asynchronous: all valid bits=0, state=IDLE, mem_req_valid=0, mem_req_addr=0, beat counter=0, flush_pend=0. Data and tag arrays are not reset.
- States:
  - IDLE: if fetch_req and miss and not flush, capture the line address {fetch_pc[31:W+2],{W+2{1'b0}}} and go to REQ next cycle. While not IDLE, inst_hit=0; fetch_stall=fetch_req.
  - REQ: mem_req_valid=1 with mem_req_addr held stable until mem_req_ready=1. Handshake cycle moves to RECV.
  - RECV: each mem_rvalid=1 cycle writes mem_rdata to word[cnt] of the target line; cnt increments. After beat LINE_WORDS-1, cnt wraps to 0 and the state moves to FILL.
  - FILL: write tag. Set valid unless flush_pend. Clear flush_pend. Return to IDLE. Lookup then re-evaluates, so a refilled line hits in the first IDLE cycle.
- mem_rvalid outside RECV is ignored. mem_rvalid cannot arrive in the REQ handshake cycle.
- Miss penalty with ready=1 and back-to-back beats: miss seen in IDLE at cycle 0; REQ at 1; RECV 2..(1+LINE_WORDS); FILL at 2+LINE_WORDS; hit at 3+LINE_WORDS.
- Flush in IDLE: all valids cleared at the next edge. The flush cycle itself reports a miss but starts no refill. The following cycle misses normally.
- Flush in REQ/RECV/FILL: sets flush_pend. The refill completes without marking its line valid, and all other valids clear at FILL. flush_pend is cleared at FILL.
- Conflict miss, same index with a different tag: the line is overwritten. The old valid bit is cleared on REQ entry, so there is no partial-line hit.
- fetch_pc changing during a refill does not abort it. The refill completes, then the new PC is looked up.
- Reset during any state aborts immediately. mem_req_valid drops asynchronously. An external memory beat in flight afterwards is ignored.

Optional Feature:
ICACHE_PERF_EN: when defined, adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
- Counters are zeroed by reset and saturate at 32'hFFFF_FFFF.
- hit counts +1 each cycle with fetch_req and inst_hit.
- miss counts +1 on each IDLE->REQ transition.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold miss (defaults). rst low 3 cycles then high; fetch_req=1, fetch_pc=0x8000_0000.
  - fetch_stall=1 immediately; mem_req_valid=1 with addr 0x8000_0000 the next cycle.
  - Beats 0x11,0x22,0x33,0x44, ready=1 → inst_hit=1, inst_out=0x11 at cycle 7.
- Same-line hits after the cold miss. fetch_pc=0x8000_000C → inst_out=0x44, hit same cycle, mem_req_valid stays 0. fetch_pc=0x8000_0004 → 0x22.
- Conflict miss. fetch_pc=0x8000_0400 (index 0, new tag) → miss, refill with 0xA0..0xA3 → hit 0xA0. Then 0x8000_0000 misses again.
- Backpressure. mem_req_ready=0 for 5 cycles → mem_req_valid=1 and addr=0x8000_0400 stable all 5 cycles, no beats written. Ready=1 proceeds to RECV.
- Flush mid-refill. flush=1 during the 2nd beat → refill completes, busy drops, and the same PC misses again. Previously valid 0x8000_0000 also misses.
- Reset mid-RECV. rst=0 after 2 beats → mem_req_valid=0, busy=0 asynchronously. After release, 0x8000_0000 misses.
